// File: rtl/apb_cmd_bridge_pkg.sv
// Shared types for the APB command bridge.
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   apb_cmd_t   : one queued register command (write flag, address, write data)
//   rsp_data_sel: read data returned to the requester for a completed transfer
package apb_bridge_pkg;

    localparam int unsigned PKG_ADDR_W = 8;
    localparam int unsigned PKG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Writes carry no read data back; reads return what the slave drove.
    function automatic logic [PKG_DATA_W-1:0] rsp_data_sel(
        input logic                  write,
        input logic [PKG_DATA_W-1:0] prdata
    );
        logic [PKG_DATA_W-1:0] data;
        if (write) begin
            data = {PKG_DATA_W{1'b0}};
        end else begin
            data = prdata;
        end
        return data;
    endfunction

endpackage

// File: rtl/apb_cmd_bridge_fifo.sv
// apb_cmd_fifo: synchronous command FIFO for the APB bridge.
// Ports:
//   clk, rst_n    clock, async active-low reset (flushes the queue)
//   push, wr_cmd  enqueue request and data (accepted when not full, or full with pop)
//   pop           dequeue the head (ignored when empty)
//   rd_cmd        current head entry
//   full, empty   occupancy flags
// Pointers carry one wrap bit above the address bits so full and empty are
// distinguishable when the address bits match.
module apb_cmd_fifo
    import apb_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  apb_cmd_t wr_cmd,
    input  logic     pop,
    output apb_cmd_t rd_cmd,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    apb_cmd_t    mem_r [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign full   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign rd_cmd = mem_r[rd_ptr_r[AW-1:0]];

    // Qualify requests against occupancy; a full FIFO may still push while popping.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (push && (!full || pop)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop && !empty) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_cmd;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_bridge.sv
// apb_cmd_bridge: APB master that turns queued valid/ready register commands
// into APB SETUP/ACCESS transfers and returns one response per command.
// Ports:
//   pclk, presetn                 APB clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  command channel (into the FIFO)
//   rsp_valid/ready/rdata/err      response channel (single held entry)
//   busy                          any activity pending (FSM, FIFO or response)
//   psel/penable/pwrite/paddr/pwdata/prdata/pready  APB master port
// A transfer waiting on pready is abandoned after TIMEOUT ACCESS cycles
// (TIMEOUT = 0 disables this) and reported with rsp_err.
module apb_cmd_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = PKG_ADDR_W,
    parameter int unsigned DATA_W     = PKG_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 32'd0) ? CNT_W'(TIMEOUT - 32'd1) : {CNT_W{1'b0}};

    apb_state_e        state_r;
    logic [CNT_W-1:0]  to_cnt_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    apb_cmd_t          cmd_in_s;
    apb_cmd_t          head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              timeout_hit_s;

    assign cmd_in_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign push_s   = cmd_valid && !fifo_full_s;

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (pclk),
        .rst_n  (presetn),
        .push   (push_s),
        .wr_cmd (cmd_in_s),
        .pop    (pop_s),
        .rd_cmd (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Start a transfer only when the response slot is free (or being drained
    // this cycle), so a completing ACCESS never overwrites a held response.
    always_comb begin
        pop_s = 1'b0;
        if ((state_r == IDLE) && !fifo_empty_s && (!rsp_valid_r || rsp_ready)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Timeout fires on the ACCESS cycle that would bring the wait count to TIMEOUT.
    always_comb begin
        timeout_hit_s = 1'b0;
        if ((TIMEOUT != 32'd0) && (to_cnt_r == TO_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer FSM, APB output registers, wait counter and response register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r     <= IDLE;
            to_cnt_r    <= {CNT_W{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r   <= SETUP;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        pwrite_r  <= head_s.write;
                        paddr_r   <= head_s.addr;
                        pwdata_r  <= head_s.wdata;
                        to_cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                SETUP: begin
                    state_r   <= ACCESS;
                    penable_r <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        // pready wins over a timeout landing on the same cycle.
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= rsp_data_sel(pwrite_r, prdata);
                    end else if (timeout_hit_s) begin
                        state_r     <= IDLE;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                    end else if (to_cnt_r != CNT_MAX) begin
                        to_cnt_r <= to_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = !fifo_full_s;
    assign busy      = (state_r != IDLE) || !fifo_empty_s || rsp_valid_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Directed self-checking bench for apb_cmd_bridge with a small APB slave model
// (configurable wait states / stuck pready, or an 8-bit timer register map).
module tb_apb_cmd_bridge;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite, pready;
    logic [7:0] paddr, pwdata, prdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    apb_cmd_bridge dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // Cycle counter (number of rising edges so far).
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic       stuck      = 1'b0;
    int         wait_cfg   = 0;
    logic       timer_mode = 1'b0;
    logic [7:0] rd_base    = 8'h00;
    int         wcnt;
    logic [7:0] tmr_cnt, tmr_ctrl, tmr_stat;

    assign pready = psel && penable && !stuck && (wcnt >= wait_cfg);
    assign prdata = !timer_mode ? (rd_base + paddr) :
                    (paddr == 8'h00) ? tmr_cnt :
                    (paddr == 8'h04) ? tmr_ctrl :
                    (paddr == 8'h08) ? tmr_stat : 8'h00;

    // Slave wait-state counter and timer registers.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt     <= 0;
            tmr_cnt  <= 8'h00;
            tmr_ctrl <= 8'h00;
            tmr_stat <= 8'h00;
        end else begin
            if (psel && penable && !pready) wcnt <= wcnt + 1;
            else                            wcnt <= 0;
            if (tmr_ctrl[0]) begin
                tmr_cnt <= tmr_cnt + 8'd1;
                if (tmr_cnt == 8'hFF) tmr_stat[0] <= 1'b1;
            end
            if (timer_mode && psel && penable && pready && pwrite) begin
                case (paddr)
                    8'h00:   tmr_cnt  <= pwdata;
                    8'h04:   tmr_ctrl <= pwdata;
                    8'h08:   tmr_stat <= tmr_stat & ~pwdata;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- APB monitor ----------------
    int         n_psel = 0, n_pen = 0, n_xfer = 0, n_addr_chg = 0, n_proto = 0;
    logic       prev_psel = 1'b0, prev_pen = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    // Count select/enable cycles, transfers, address changes and protocol slips.
    always @(negedge pclk) begin
        if (psel)    n_psel <= n_psel + 1;
        if (penable) n_pen  <= n_pen + 1;
        if (psel && !prev_psel) n_xfer <= n_xfer + 1;
        if (psel && prev_psel && (paddr != prev_addr)) n_addr_chg <= n_addr_chg + 1;
        if ((penable && !psel) || (penable && !prev_pen && !(prev_psel && psel)))
            n_proto <= n_proto + 1;
        prev_psel <= psel;
        prev_pen  <= penable;
        prev_addr <= paddr;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, output int hs_cyc);
        int t;
        t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && t < 200) begin tick(); t++; end
        check("cmd_accept_bound", 32'(t < 200), 32'd1);
        hs_cyc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] rd, output logic err, output int at_cyc);
        int t;
        t = 0;
        while (!rsp_valid && t < 100) begin tick(); t++; end
        check("rsp_bound", 32'(t < 100), 32'd1);
        rd = rsp_rdata; err = rsp_err; at_cyc = cyc;
        tick();
    endtask

    task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int lat);
        int hs, at;
        send(w, a, d, hs);
        get_rsp(rd, err, at);
        lat = at - hs;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] rd;
        logic       err;
        int         lat, hs, p0, e0, x0, t;
        logic [7:0] exp_rd [5];

        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 8'h00; cmd_wdata = 8'h00; rsp_ready = 1'b1;
        tick(); tick(); tick();
        presetn = 1'b1;
        tick(); tick();

        // Reset state
        check("reset_flags", {25'd0, cmd_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite}, 32'h40);
        check("reset_paddr", {24'd0, paddr}, 32'h0);
        check("reset_pwdata", {24'd0, pwdata}, 32'h0);
        check("reset_rdata", {24'd0, rsp_rdata}, 32'h0);

        // 1. zero-wait write 0x13 to 0x00
        p0 = n_psel; e0 = n_pen;
        xact(1'b1, 8'h00, 8'h13, rd, err, lat);
        tick();
        check("t1_latency", lat, 32'd4);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_rdata", {24'd0, rd}, 32'h0);
        check("t1_psel_cycles", n_psel - p0, 32'd2);
        check("t1_penable_cycles", n_pen - e0, 32'd1);
        check("t1_pwdata", {24'd0, pwdata}, 32'h13);
        check("t1_pwrite", {31'd0, pwrite}, 32'd1);

        // 2. read 0x04 with 3 wait states, slave returns 0xA5
        wait_cfg = 3; rd_base = 8'hA1;
        e0 = n_pen;
        xact(1'b0, 8'h04, 8'h00, rd, err, lat);
        tick();
        check("t2_rdata", {24'd0, rd}, 32'hA5);
        check("t2_err", {31'd0, err}, 32'd0);
        check("t2_latency", lat, 32'd7);
        check("t2_penable_cycles", n_pen - e0, 32'd4);
        check("t2_paddr", {24'd0, paddr}, 32'h04);
        wait_cfg = 0;

        // 3. pready stuck low -> timeout after 16 ACCESS cycles
        stuck = 1'b1;
        e0 = n_pen;
        xact(1'b0, 8'h10, 8'h00, rd, err, lat);
        tick();
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_rdata", {24'd0, rd}, 32'h0);
        check("t3_penable_cycles", n_pen - e0, 32'd16);
        check("t3_latency", lat, 32'd19);
        stuck = 1'b0;
        xact(1'b1, 8'h20, 8'h55, rd, err, lat);
        check("t3_next_err", {31'd0, err}, 32'd0);
        check("t3_next_latency", lat, 32'd4);
        check("t3_next_pwdata", {24'd0, pwdata}, 32'h55);

        // 4. five commands with the response channel stalled
        rsp_ready = 1'b0; rd_base = 8'h10;
        x0 = n_xfer;
        send(1'b0, 8'h01, 8'h00, hs);
        send(1'b0, 8'h02, 8'h00, hs);
        send(1'b1, 8'h03, 8'h77, hs);
        send(1'b0, 8'h04, 8'h00, hs);
        send(1'b0, 8'h05, 8'h00, hs);
        check("t4_full", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t4_one_xfer", n_xfer - x0, 32'd1);
        check("t4_still_full", {31'd0, cmd_ready}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd1);
        rsp_ready = 1'b1;
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h12; exp_rd[2] = 8'h00;
        exp_rd[3] = 8'h14; exp_rd[4] = 8'h15;
        for (int i = 0; i < 5; i++) begin
            get_rsp(rd, err, t);
            check($sformatf("t4_rdata_%0d", i), {24'd0, rd}, {24'd0, exp_rd[i]});
            check($sformatf("t4_err_%0d", i), {31'd0, err}, 32'd0);
        end
        tick();
        check("t4_total_xfers", n_xfer - x0, 32'd5);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // 5. reset during ACCESS with a second command queued
        stuck = 1'b1;
        send(1'b0, 8'h30, 8'h00, hs);
        send(1'b0, 8'h31, 8'h00, hs);
        t = 0;
        while (!penable && t < 20) begin tick(); t++; end
        check("t5_reach_access", {31'd0, penable}, 32'd1);
        tick(); tick();
        #2 presetn = 1'b0;
        #1;
        check("t5_psel_drop", {31'd0, psel}, 32'd0);
        check("t5_penable_drop", {31'd0, penable}, 32'd0);
        tick(); tick();
        presetn = 1'b1; stuck = 1'b0;
        x0 = n_xfer;
        for (int i = 0; i < 6; i++) tick();
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t5_no_xfer", n_xfer - x0, 32'd0);

        // 6. timer: load 0xFE, enable, observe overflow status
        timer_mode = 1'b1;
        xact(1'b1, 8'h00, 8'hFE, rd, err, lat);
        check("t6_load_err", {31'd0, err}, 32'd0);
        xact(1'b0, 8'h00, 8'h00, rd, err, lat);
        check("t6_cnt_rd", {24'd0, rd}, 32'hFE);
        xact(1'b1, 8'h04, 8'h01, rd, err, lat);
        check("t6_en_err", {31'd0, err}, 32'd0);
        xact(1'b0, 8'h08, 8'h00, rd, err, lat);
        check("t6_status", {24'd0, rd}, 32'h01);
        check("t6_irq", {31'd0, tmr_stat[0]}, 32'd1);
        xact(1'b0, 8'h04, 8'h00, rd, err, lat);
        check("t6_ctrl", {24'd0, rd}, 32'h01);
        xact(1'b1, 8'h04, 8'h00, rd, err, lat);
        xact(1'b1, 8'h08, 8'h01, rd, err, lat);
        xact(1'b0, 8'h08, 8'h00, rd, err, lat);
        check("t6_status_clr", {24'd0, rd}, 32'h00);
        check("t6_err", {31'd0, err}, 32'd0);

        check("proto_violations", n_proto, 32'd0);
        check("addr_changes", n_addr_chg, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
